// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests the word at pc_value,
// registers the response into a decode slot and raises a fault on misaligned PCs.
module instruction_fetch #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_value,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic        pc_en,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        if_fault,
   input  logic        id_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        aligned;

   assign aligned   = (pc_value[1:0] == 2'b00);
   assign imem_req  = (state_q == REQ) && !flush && aligned;
   assign imem_addr = pc_value;
   assign pc_en     = imem_req && imem_gnt;

   assign if_instr = instr_q;
   assign if_pc    = pc_q;
   assign if_valid = valid_q;
   assign if_fault = fault_q;

   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      drop_d   = drop_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      fault_d  = fault_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (!flush) begin
               if (!aligned) begin
                  state_d = FAULT;
                  valid_d = 1'b1;
                  fault_d = 1'b1;
                  instr_d = NOP_INSTR;
                  pc_d    = pc_value;
               end else if (imem_gnt) begin
                  req_pc_d = pc_value;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            // A redirect while waiting poisons the in-flight response.
            if (imem_rvalid) begin
               if (drop_q || flush) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  instr_d = imem_rdata;
                  pc_d    = req_pc_q;
                  valid_d = 1'b1;
                  fault_d = 1'b0;
                  state_d = HOLD;
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (flush || id_ready) begin
               valid_d = 1'b0;
               state_d = REQ;
            end
         end
         FAULT: begin
            // Parked here after handoff until a redirect supplies a new PC.
            if (flush) begin
               valid_d = 1'b0;
               fault_d = 1'b0;
               state_d = REQ;
            end else if (valid_q && id_ready) begin
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         req_pc_q <= 32'h0;
         drop_q   <= 1'b0;
         instr_q  <= 32'h0;
         pc_q     <= 32'h0;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
      end
   end

endmodule
